fetch_ctrl: RTL

Fetch-stage sequencer for the MIPS R2000 pipeline. It owns the program counter and issues instruction-memory requests over a req/ack handshake. Returned instructions go into a 2-entry buffer that the ID stage drains under a stall signal. Redirects are arbitrated with priority exception > branch > sequential, and the block squashes in-flight and buffered fetches on a redirect.

---
 rtl/fetch_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, issues req/ack instruction fetches and buffers up to two
// returned instructions for ID. Optional delay-slot branch handling under `FETCH_DELAY_SLOT_EN.
module fetch_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h8000_0080
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    input  logic        exc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o
);

    typedef enum logic [1:0] {BOOT, FETCH, DRAIN} state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n, tgt, tgt_n;
    logic        pend, pend_n;
    logic [1:0]  count, cnt_n, base;
    logic        req, req_n;
    logic [31:0] pc0, pc1, inst0, inst1;
    logic [31:0] pc0_n, pc1_n, inst0_n, inst1_n;
    logic        pop, ack, outst, push, flush, keep;
    logic [31:0] br_tgt, exc_tgt;

    assign pop     = (count != 2'd0) && !stall_i;
    assign ack     = req && imem_ack_i;
    assign outst   = req && !imem_ack_i;
    assign br_tgt  = {br_target_i[31:2], 2'b00};
    assign exc_tgt = {EXC_VECTOR[31:2], 2'b00};
    assign base    = count - {1'b0, pop};

    always_comb begin
        state_n = state;
        pc_n    = pc;
        tgt_n   = tgt;
        pend_n  = pend;
        push    = 1'b0;
        flush   = 1'b0;
        keep    = 1'b0;
        case (state)
            BOOT: state_n = FETCH;
            FETCH: begin
                if (exc_i) begin
                    flush  = 1'b1;
                    pend_n = 1'b0;
                    if (outst) begin
                        state_n = DRAIN;
                        tgt_n   = exc_tgt;
                    end else begin
                        pc_n = exc_tgt;
                    end
                end else if (br_taken_i) begin
`ifdef FETCH_DELAY_SLOT_EN
                    // Head entry (or the next returned instruction) is the delay slot.
                    if (count != 2'd0) begin
                        keep   = 1'b1;
                        pend_n = 1'b0;
                        if (outst) begin
                            state_n = DRAIN;
                            tgt_n   = br_tgt;
                        end else begin
                            pc_n = br_tgt;
                        end
                    end else if (ack) begin
                        push   = 1'b1;
                        pc_n   = br_tgt;
                        pend_n = 1'b0;
                    end else begin
                        pend_n = 1'b1;
                        tgt_n  = br_tgt;
                    end
`else
                    flush  = 1'b1;
                    pend_n = 1'b0;
                    if (outst) begin
                        state_n = DRAIN;
                        tgt_n   = br_tgt;
                    end else begin
                        pc_n = br_tgt;
                    end
`endif
                end else if (ack) begin
                    push   = 1'b1;
                    pc_n   = pend ? tgt : pc + 32'd4;
                    pend_n = 1'b0;
                end
            end
            DRAIN: begin
                if (exc_i) begin
                    flush  = 1'b1;
                    pend_n = 1'b0;
                    tgt_n  = exc_tgt;
                end else if (br_taken_i) begin
`ifdef FETCH_DELAY_SLOT_EN
                    keep  = (count != 2'd0);
                    flush = (count == 2'd0);
`else
                    flush = 1'b1;
`endif
                    tgt_n = br_tgt;
                end
                // Squashed data is dropped; resume at the (possibly updated) target.
                if (ack) begin
                    state_n = FETCH;
                    pc_n    = tgt_n;
                end
            end
            default: state_n = BOOT;
        endcase
    end

    always_comb begin
        pc0_n   = pc0;
        pc1_n   = pc1;
        inst0_n = inst0;
        inst1_n = inst1;
        cnt_n   = count;
        if (flush) begin
            cnt_n = 2'd0;
        end else if (keep) begin
            cnt_n = pop ? 2'd0 : 2'd1;
        end else begin
            if (pop) begin
                pc0_n   = pc1;
                inst0_n = inst1;
            end
            if (push) begin
                if (base == 2'd0) begin
                    pc0_n   = pc;
                    inst0_n = imem_rdata_i;
                end else begin
                    pc1_n   = pc;
                    inst1_n = imem_rdata_i;
                end
            end
            cnt_n = base + {1'b0, push};
        end
        req_n = (state_n == DRAIN) || ((state_n == FETCH) && (cnt_n != 2'd2));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
            pc    <= RESET_VECTOR;
            tgt   <= RESET_VECTOR;
            pend  <= 1'b0;
            count <= 2'd0;
            req   <= 1'b0;
            pc0   <= 32'd0;
            pc1   <= 32'd0;
            inst0 <= 32'd0;
            inst1 <= 32'd0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            tgt   <= tgt_n;
            pend  <= pend_n;
            count <= cnt_n;
            req   <= req_n;
            pc0   <= pc0_n;
            pc1   <= pc1_n;
            inst0 <= inst0_n;
            inst1 <= inst1_n;
        end
    end

    assign imem_req_o  = req;
    assign imem_addr_o = pc;
    assign if_valid_o  = (count != 2'd0);
    assign if_pc_o     = pc0;
    assign if_inst_o   = inst0;

endmodule
